// File: rtl/msu_pkg.sv
// Shared types and defaults for the MSU read arbiter.
// Holds the FSM state encoding and the audio burst limit.
package msu_pkg;

  localparam int AUDIO_BURST_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AUDIO_RD,
    S_DATA_RD,
    S_DATA_HIT
  } state_e;

endpackage

// File: rtl/msu_word_cache.sv
// Single-word data-track cache: tag, valid bit and byte-lane select.
// Filled from the memory word returned by a data read.
module msu_word_cache
  import msu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fill,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic [29:0] look_tag,
  input  logic        force_miss,
  input  logic [1:0]  lane,
  output logic        hit,
  output logic [7:0]  lane_byte
);

  logic        valid_q, valid_d;
  logic [29:0] tag_q, tag_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    word_d  = word_q;
    if (fill) begin
      valid_d = 1'b1;
      tag_d   = fill_tag;
      word_d  = fill_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      word_q  <= word_d;
    end
  end

  assign hit = valid_q & (tag_q == look_tag) & ~force_miss;

  always_comb begin
    lane_byte = word_q[7:0];
    unique case (lane)
      2'd0: lane_byte = word_q[7:0];
      2'd1: lane_byte = word_q[15:8];
      2'd2: lane_byte = word_q[23:16];
      2'd3: lane_byte = word_q[31:24];
    endcase
  end

endmodule

// File: rtl/msu_read_arb.sv
// Arbitrates audio-FIFO and data-track reads onto one memory port,
// with bounded audio bursts and a one-word data cache.
module msu_read_arb
  import msu_pkg::*;
#(
  parameter int AUDIO_BURST = AUDIO_BURST_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        data_seek,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  output logic [7:0]  data,
  output logic        data_ack,
  input  logic        audio_req,
  input  logic [31:0] audio_addr,
  output logic [31:0] audio_data,
  output logic        audio_ack,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(AUDIO_BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(AUDIO_BURST);

  state_e state_q, state_d;

  logic          audio_pend_q, audio_pend_d;
  logic          data_pend_q, data_pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seek_q;
  logic          force_q, force_d;
  logic          abort_q, abort_d;
  logic          mem_rd_q, mem_rd_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [1:0]    lane_q, lane_d;
  logic [7:0]    data_q, data_d;
  logic          data_ack_q, data_ack_d;
  logic [31:0]   audio_data_q, audio_data_d;
  logic          audio_ack_q, audio_ack_d;

  logic       seek_rise;
  logic       audio_grant, data_grant;
  logic       audio_clr, data_clr;
  logic       fill, hit;
  logic [7:0] lane_byte;
  logic       addr_unused;

  assign addr_unused = ^audio_addr[1:0];
  assign seek_rise   = data_seek & ~seek_q;

  msu_word_cache u_cache (
    .clk        (CLK),
    .rst        (RESET),
    .fill       (fill),
    .fill_tag   (mem_addr_q[31:2]),
    .fill_data  (mem_rdata),
    .look_tag   (data_addr[31:2]),
    .force_miss (force_q),
    .lane       (lane_q),
    .hit        (hit),
    .lane_byte  (lane_byte)
  );

  always_comb begin
    state_d      = state_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    lane_d       = lane_q;
    data_d       = data_q;
    data_ack_d   = 1'b0;
    audio_data_d = audio_data_q;
    audio_ack_d  = 1'b0;
    abort_d      = abort_q;
    audio_grant  = 1'b0;
    data_grant   = 1'b0;
    audio_clr    = 1'b0;
    data_clr     = 1'b0;
    fill         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (audio_pend_q && (cnt_q < BMAX)) begin
          audio_grant = 1'b1;
          state_d     = S_AUDIO_RD;
          mem_rd_d    = 1'b1;
          mem_addr_d  = {audio_addr[31:2], 2'b00};
        end else if (data_pend_q) begin
          data_grant = 1'b1;
          lane_d     = data_addr[1:0];
          abort_d    = seek_rise;
          if (hit) begin
            state_d = S_DATA_HIT;
          end else begin
            state_d    = S_DATA_RD;
            mem_rd_d   = 1'b1;
            mem_addr_d = {data_addr[31:2], 2'b00};
          end
        end
      end
      S_AUDIO_RD: begin
        if (mem_ack) begin
          audio_data_d = mem_rdata;
          audio_ack_d  = 1'b1;
          audio_clr    = 1'b1;
          mem_rd_d     = 1'b0;
          state_d      = S_IDLE;
        end
      end
      S_DATA_RD: begin
        abort_d = abort_q | seek_rise;
        if (mem_ack) begin
          fill     = 1'b1;
          mem_rd_d = 1'b0;
          abort_d  = 1'b0;
          // A seek that arrived mid-read gets its own forced-miss pass
          state_d  = (abort_q | seek_rise) ? S_IDLE : S_DATA_HIT;
        end
      end
      S_DATA_HIT: begin
        state_d = S_IDLE;
        abort_d = 1'b0;
        if (!abort_q) begin
          data_d     = lane_byte;
          data_ack_d = 1'b1;
          data_clr   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    audio_pend_d = (audio_pend_q & ~audio_clr) | audio_req;
    data_pend_d  = (data_pend_q & ~data_clr) | data_req | seek_rise;
    force_d      = (force_q & ~data_grant) | seek_rise;
    cnt_d        = cnt_q;
    if (!data_pend_q || data_grant) begin
      cnt_d = '0;
    end else if (audio_grant && (cnt_q < BMAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      audio_pend_q <= 1'b0;
      data_pend_q  <= 1'b0;
      cnt_q        <= '0;
      seek_q       <= 1'b0;
      force_q      <= 1'b0;
      abort_q      <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      lane_q       <= '0;
      data_q       <= '0;
      data_ack_q   <= 1'b0;
      audio_data_q <= '0;
      audio_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      audio_pend_q <= audio_pend_d;
      data_pend_q  <= data_pend_d;
      cnt_q        <= cnt_d;
      seek_q       <= data_seek;
      force_q      <= force_d;
      abort_q      <= abort_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      lane_q       <= lane_d;
      data_q       <= data_d;
      data_ack_q   <= data_ack_d;
      audio_data_q <= audio_data_d;
      audio_ack_q  <= audio_ack_d;
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign data       = data_q;
  assign data_ack   = data_ack_q;
  assign audio_data = audio_data_q;
  assign audio_ack  = audio_ack_q;

endmodule

// File: tb/tb_msu_read_arb.sv
// Directed bench for msu_read_arb with a latency-programmable memory.
// Expected values are hand-computed from the memory word pattern.
module tb_msu_read_arb;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        data_seek, data_req, audio_req;
  logic [31:0] data_addr, audio_addr;
  logic [7:0]  data;
  logic        data_ack, audio_ack;
  logic [31:0] audio_data;
  logic        mem_rd;
  logic [31:0] mem_addr, mem_rdata;
  logic        mem_ack, model_ack, stray_ack;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int n_aack = 0, n_dack = 0, n_coinc = 0, n_rdstart = 0;
  int aack_cyc = 0, dack_cyc = 0;
  logic rd_prev = 1'b0;
  logic [31:0] rd_log[$];

  int mem_lat = 0;
  logic mem_hold = 1'b0;

  assign mem_ack = model_ack | stray_ack;

  msu_read_arb dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .data_seek  (data_seek),
    .data_req   (data_req),
    .data_addr  (data_addr),
    .data       (data),
    .data_ack   (data_ack),
    .audio_req  (audio_req),
    .audio_addr (audio_addr),
    .audio_data (audio_data),
    .audio_ack  (audio_ack),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDDCCBBAA;
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  initial begin
    int wcnt;
    wcnt = 0;
    model_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge CLK);
      #1;
      model_ack = 1'b0;
      if (mem_rd && !mem_hold) begin
        if (wcnt >= mem_lat) begin
          model_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (mem_rd && mem_ack) rd_log.push_back(mem_addr);
    if (mem_rd && !rd_prev) n_rdstart++;
    rd_prev = mem_rd;
    if (audio_ack) begin
      n_aack++;
      aack_cyc = cyc;
    end
    if (data_ack) begin
      n_dack++;
      dack_cyc = cyc;
    end
    if (audio_ack && data_ack) n_coinc++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int b_rd, b_log, b_aack, b_dack;
    RESET      = 1'b1;
    data_seek  = 1'b0;
    data_req   = 1'b0;
    audio_req  = 1'b0;
    data_addr  = '0;
    audio_addr = '0;
    stray_ack  = 1'b0;
    tick(3);
    RESET = 1'b0;
    tick(1);

    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_data", 32'(data), 0);
    check("rst_data_ack", 32'(data_ack), 0);
    check("rst_audio_data", audio_data, 0);
    check("rst_audio_ack", 32'(audio_ack), 0);

    // seek miss at 0x102
    mem_lat = 3;
    b_rd = n_rdstart; b_log = rd_log.size(); b_dack = n_dack;
    data_addr = 32'h102;
    data_seek = 1'b1;
    tick(20);
    data_seek = 1'b0;
    tick(2);
    check("seek_rd_cnt", 32'(n_rdstart - b_rd), 1);
    check("seek_rd_addr", (rd_log.size() > b_log) ? rd_log[b_log] : 32'hX, 32'h100);
    check("seek_data", 32'(data), 32'hCC);
    check("seek_ack_cnt", 32'(n_dack - b_dack), 1);

    // cache hit at 0x103
    b_rd = n_rdstart;
    data_addr = 32'h103;
    data_req = 1'b1;
    tick(1);
    data_req = 1'b0;
    tick(1);
    check("hit_ack_early", 32'(data_ack), 0);
    tick(1);
    check("hit_ack_t2", 32'(data_ack), 1);
    check("hit_data", 32'(data), 32'hDD);
    tick(1);
    check("hit_ack_pulse", 32'(data_ack), 0);
    check("hit_no_rd", 32'(n_rdstart - b_rd), 0);

    // simultaneous audio and data (miss)
    mem_lat = 2;
    b_log = rd_log.size(); b_aack = n_aack; b_dack = n_dack;
    audio_addr = 32'h400;
    data_addr  = 32'h306;
    audio_req = 1'b1;
    data_req  = 1'b1;
    tick(1);
    audio_req = 1'b0;
    data_req  = 1'b0;
    tick(25);
    check("sim_rd0", (rd_log.size() > b_log) ? rd_log[b_log] : 32'hX, 32'h400);
    check("sim_rd1", (rd_log.size() > b_log + 1) ? rd_log[b_log + 1] : 32'hX, 32'h304);
    check("sim_audio_data", audio_data, 32'hA1A50400);
    check("sim_data", 32'(data), 32'hA1);
    check("sim_aack_cnt", 32'(n_aack - b_aack), 1);
    check("sim_dack_cnt", 32'(n_dack - b_dack), 1);
    check("sim_order", 32'(aack_cyc < dack_cyc), 1);

    // audio burst limit with data pending
    mem_lat = 0;
    b_log = rd_log.size(); b_dack = n_dack;
    audio_addr = 32'h600;
    data_addr  = 32'h500;
    audio_req = 1'b1;
    data_req  = 1'b1;
    tick(1);
    data_req = 1'b0;
    tick(40);
    audio_req = 1'b0;
    tick(10);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_audio%0d", i),
            (rd_log.size() > b_log + i) ? rd_log[b_log + i] : 32'hX, 32'h600);
    end
    check("burst_data", (rd_log.size() > b_log + 4) ? rd_log[b_log + 4] : 32'hX, 32'h500);
    check("burst_after", (rd_log.size() > b_log + 5) ? rd_log[b_log + 5] : 32'hX, 32'h600);
    check("burst_dack_cnt", 32'(n_dack - b_dack), 1);

    // seek during DATA_RD
    mem_lat = 3;
    b_log = rd_log.size(); b_dack = n_dack;
    data_addr = 32'h100;
    data_req = 1'b1;
    tick(1);
    data_req = 1'b0;
    tick(2);
    check("abort_rd_busy", 32'(mem_rd), 1);
    data_addr = 32'h203;
    data_seek = 1'b1;
    tick(25);
    data_seek = 1'b0;
    tick(2);
    check("abort_rd0", (rd_log.size() > b_log) ? rd_log[b_log] : 32'hX, 32'h100);
    check("abort_rd1", (rd_log.size() > b_log + 1) ? rd_log[b_log + 1] : 32'hX, 32'h200);
    check("abort_rd_cnt", 32'(rd_log.size() - b_log), 2);
    check("abort_dack_cnt", 32'(n_dack - b_dack), 1);
    check("abort_data", 32'(data), 32'hA7);

    // reset during AUDIO_RD, stray ack afterwards
    mem_hold = 1'b1;
    b_aack = n_aack;
    audio_addr = 32'h700;
    audio_req = 1'b1;
    tick(1);
    audio_req = 1'b0;
    tick(1);
    check("rst_mid_rd", 32'(mem_rd), 1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check("rst_mid_drop", 32'(mem_rd), 0);
    tick(1);
    stray_ack = 1'b1;
    tick(1);
    stray_ack = 1'b0;
    tick(5);
    mem_hold = 1'b0;
    check("rst_mid_aack", 32'(n_aack - b_aack), 0);
    check("rst_mid_rd_low", 32'(mem_rd), 0);
    check("rst_mid_addr", mem_addr, 0);
    check("rst_mid_adata", audio_data, 0);
    check("rst_mid_data", 32'(data), 0);
    check("rst_mid_dack", 32'(data_ack), 0);

    check("ack_coinc", 32'(n_coinc), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
